// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead receive FIFO and sticky error flags.
// Bytes are pushed the cycle after a good stop bit and popped via rd_en.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx,
  output logic [7:0]                      rd_data,
  output logic                            rd_valid,
  input  logic                            rd_en,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            frame_err,
  output logic                            overflow,
  input  logic                            err_clr
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          start_edge, half_tick, bit_tick;
  logic          cnt_clr, idx_clr, shift_en, push_c, ferr_c;
  logic          push_q;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign start_edge = rx_d & ~rx_s;
  assign half_tick  = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign bit_tick   = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_edge) state_d = START;
      START:   if (half_tick) state_d = rx_s ? IDLE : DATA;
      DATA:    if (bit_tick && idx == 3'd7) state_d = STOP;
      STOP:    if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    push_c   = 1'b0;
    ferr_c   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        idx_clr = 1'b1;
      end
      START: cnt_clr = half_tick;
      DATA: begin
        cnt_clr  = bit_tick;
        shift_en = bit_tick;
      end
      STOP: begin
        cnt_clr = bit_tick;
        push_c  = bit_tick & rx_s;
        ferr_c  = bit_tick & ~rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit timing counter, data shift register and deferred push strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      push_q <= 1'b0;
    end else begin
      cnt    <= cnt_clr ? '0 : cnt + CW'(1);
      push_q <= push_c;
      if (idx_clr) begin
        idx <= '0;
      end else if (shift_en) begin
        shift[idx] <= rx_s;
        idx        <= idx + 3'd1;
      end
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [AW:0]   count_n;
  logic          pop, full, wr_ok;

  assign pop   = rd_en & rd_valid;
  assign full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign wr_ok = push_q & (~full | pop);

  always_comb begin
    rptr_n  = pop ? rptr + AW'(1) : rptr;
    count_n = fifo_count;
    if (wr_ok && !pop)      count_n = fifo_count + (AW+1)'(1);
    else if (!wr_ok && pop) count_n = fifo_count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= shift;
  end

  // Head byte is registered; bypass the write when it lands on the new head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      rptr       <= rptr_n;
      fifo_count <= count_n;
      rd_valid   <= (count_n != '0);
      if (count_n == '0)                rd_data <= '0;
      else if (wr_ok && wptr == rptr_n) rd_data <= shift;
      else                              rd_data <= mem[rptr_n];
      frame_err  <= ferr_c | (frame_err & ~err_clr);
      overflow   <= (push_q & full & ~pop) | (overflow & ~err_clr);
    end
  end

endmodule
